// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared CPU instruction field positions, fetch FSM encoding and default widths
package instr_fetch_unit_pkg;
    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;
    localparam int OPC_MSB     = 15;
    localparam int OPC_LSB     = 12;
    localparam int FUNC_MSB    = 5;
    localparam int FUNC_LSB    = 0;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// instr_fetch_unit_pc_reg: program counter with reset value, jump load and wrapping increment
//   clk, rst_n : clock, async active-low reset (pc returns to RESET_PC)
//   load       : advance the pc this cycle (controller handshake)
//   jump       : when loading, take target instead of pc+1
//   target     : jump destination
//   pc         : current program counter
module instr_fetch_unit_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              jump,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);
    logic [ADDR_W-1:0] pc_d, pc_q;
    always_comb pc_d = load ? (jump ? target : pc_q + ADDR_W'(1)) : pc_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    assign pc = pc_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: pc holder issuing single-outstanding imem reads and presenting the fetched word to the controller
//   clk, rst_n               : clock, async active-low reset
//   en                       : run enable; low stops new fetches from starting
//   imem_req, imem_addr      : one-cycle read strobe and word address (address tracks pc)
//   imem_rvalid, imem_rdata  : read return, only accepted while waiting
//   instr_valid, instr_ready : handshake for the presented instruction
//   instr, opcode, func      : instruction register and its field slices
//   instr_pc                 : address the presented instruction came from
//   pc_flag, jump_target     : redirect request, sampled only on handshake
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [5:0]         func,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               pc_flag,
    input  logic [ADDR_W-1:0]  jump_target
);
    fetch_state_e       state_d, state_q;
    logic               imem_req_d, imem_req_q;
    logic               instr_valid_d, instr_valid_q;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic [ADDR_W-1:0]  instr_pc_d, instr_pc_q;
    logic [ADDR_W-1:0]  pc;
    logic               handshake;

    // instr_valid is only ever set in HOLD, so this can only fire there
    assign handshake = instr_valid_q & instr_ready;

    instr_fetch_unit_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (handshake),
        .jump   (pc_flag),
        .target (jump_target),
        .pc     (pc)
    );

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            IDLE: state_d = en ? REQ : IDLE;
            REQ:  state_d = WAIT;
            WAIT: if (imem_rvalid) begin
                instr_d       = imem_rdata;
                instr_pc_d    = pc;
                instr_valid_d = 1'b1;
                state_d       = HOLD;
            end
            HOLD: if (handshake) begin
                instr_valid_d = 1'b0;
                state_d       = en ? REQ : IDLE;
            end
        endcase
        // strobe is registered, so it is derived from the state being entered
        imem_req_d = state_d == REQ;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q       <= IDLE;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= RESET_PC;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign opcode      = instr_q[OPC_MSB:OPC_LSB];
    assign func        = instr_q[FUNC_MSB:FUNC_LSB];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed table-driven bench for instr_fetch_unit with a variable-latency memory model
module tb_instr_fetch_unit;
    logic        clk = 0, rst_n = 0, en = 0, instr_ready = 0, pc_flag = 0;
    logic [7:0]  jump_target = 8'hEE;
    logic        imem_req, imem_rvalid, instr_valid;
    logic [7:0]  imem_addr, instr_pc;
    logic [15:0] imem_rdata, instr;
    logic [3:0]  opcode;
    logic [5:0]  func;
    logic        w_req, w_valid;
    logic [7:0]  w_addr, w_ipc;
    logic [15:0] w_instr;
    logic [3:0]  w_opc;
    logic [5:0]  w_func;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .en(en), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .opcode(opcode), .func(func),
        .instr_pc(instr_pc), .pc_flag(pc_flag), .jump_target(jump_target)
    );

    instr_fetch_unit #(.RESET_PC(8'hFF)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(w_valid),
        .instr_ready(instr_ready), .instr(w_instr), .opcode(w_opc), .func(w_func),
        .instr_pc(w_ipc), .pc_flag(pc_flag), .jump_target(jump_target)
    );

    always #5 clk = ~clk;

    int          lat = 1, cnt = 0;
    logic [7:0]  mem_addr = 0;
    logic        fixed_en = 0, manual_rv = 0, mem_clr = 0;
    logic [15:0] fixed_data = 0;

    always @(posedge clk)
        if (mem_clr) cnt <= 0;
        else if (imem_req) begin
            cnt <= lat;
            mem_addr <= imem_addr;
        end else if (cnt > 0) cnt <= cnt - 1;
    assign imem_rvalid = (cnt == 1) | manual_rv;
    assign imem_rdata  = fixed_en ? fixed_data : {8'h12, mem_addr};

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int cyc, output int reqs);
        cyc = 0;
        reqs = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (imem_req) reqs++;
        end while (!instr_valid && cyc < 50);
        chk("valid_seen", instr_valid, 1);
    endtask

    task automatic handshake(input logic flag, input logic [7:0] tgt);
        instr_ready = 1;
        pc_flag = flag;
        jump_target = tgt;
        @(negedge clk);
        instr_ready = 0;
        pc_flag = 0;
        jump_target = 8'hEE;
    endtask

    typedef struct {
        int         delay;
        logic       flag;
        logic [7:0] tgt;
        int         next_lat;
        logic [7:0] exp_next;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, reqs;
        logic [7:0]  cur;
        logic [15:0] saved;
        tbl[0] = '{0, 1'b0, 8'h00, 1, 8'h01};
        tbl[1] = '{0, 1'b0, 8'h00, 1, 8'h02};
        tbl[2] = '{0, 1'b0, 8'h00, 1, 8'h03};
        tbl[3] = '{5, 1'b0, 8'h00, 1, 8'h04};
        tbl[4] = '{0, 1'b1, 8'h40, 1, 8'h40};
        tbl[5] = '{2, 1'b0, 8'h00, 4, 8'h41};
        tbl[6] = '{0, 1'b1, 8'h41, 2, 8'h41};
        tbl[7] = '{0, 1'b0, 8'h00, 1, 8'h42};

        en = 1;
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 8'h00);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_func", func, 0);
        chk("rst_instr_pc", instr_pc, 8'h00);
        chk("rst_wrap_addr", w_addr, 8'hFF);
        rst_n = 1;
        @(negedge clk);
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 8'h00);
        chk("wrap_first_addr", w_addr, 8'hFF);
        chk("first_valid_early", instr_valid, 0);
        @(negedge clk);
        chk("first_valid_early2", instr_valid, 0);
        chk("req_one_cycle", imem_req, 0);
        @(negedge clk);
        chk("first_valid", instr_valid, 1);
        cur = 8'h00;

        for (int i = 0; i < 8; i++) begin
            chk("tbl_valid", instr_valid, 1);
            chk("tbl_instr", instr, {8'h12, cur});
            chk("tbl_instr_pc", instr_pc, cur);
            chk("tbl_opcode", opcode, 4'h1);
            chk("tbl_func", func, cur[5:0]);
            saved = instr;
            reqs = 0;
            pc_flag = 1;
            jump_target = 8'hEE;
            for (int d = 0; d < tbl[i].delay; d++) begin
                @(negedge clk);
                if (imem_req) reqs++;
            end
            pc_flag = 0;
            if (tbl[i].delay > 0) begin
                chk("bp_no_req", reqs, 0);
                chk("bp_stable", instr, saved);
                chk("bp_valid", instr_valid, 1);
            end
            lat = tbl[i].next_lat;
            handshake(tbl[i].flag, tbl[i].tgt);
            chk("hs_req", imem_req, 1);
            chk("hs_addr", imem_addr, tbl[i].exp_next);
            chk("hs_valid_clr", instr_valid, 0);
            if (i == 0) chk("wrap_addr", w_addr, 8'h00);
            wait_valid(cyc, reqs);
            chk("lat_cycles", cyc, tbl[i].next_lat + 1);
            chk("single_req", reqs, 0);
            cur = tbl[i].exp_next;
        end

        fixed_en = 1;
        fixed_data = 16'hF000;
        lat = 4;
        handshake(1'b0, 8'h00);
        chk("f_req_addr", imem_addr, 8'h43);
        wait_valid(cyc, reqs);
        chk("f_cycles", cyc, 5);
        chk("f_one_pulse", reqs, 0);
        chk("f_instr", instr, 16'hF000);
        chk("f_opcode", opcode, 4'hF);
        chk("f_func", func, 6'd0);
        fixed_en = 0;

        lat = 3;
        handshake(1'b0, 8'h00);
        chk("en_req_addr", imem_addr, 8'h44);
        @(negedge clk);
        en = 0;
        wait_valid(cyc, reqs);
        chk("en_instr_pc", instr_pc, 8'h44);
        handshake(1'b0, 8'h00);
        chk("en_idle_noreq", imem_req, 0);
        chk("en_pc_adv", imem_addr, 8'h45);
        reqs = 0;
        repeat (4) begin
            @(negedge clk);
            if (imem_req) reqs++;
        end
        chk("en_idle_quiet", reqs, 0);
        en = 1;
        @(negedge clk);
        chk("en_resume_req", imem_req, 1);
        chk("en_resume_addr", imem_addr, 8'h45);
        @(negedge clk);
        rst_n = 0;
        en = 0;
        mem_clr = 1;
        #1;
        chk("arst_addr", imem_addr, 8'h00);
        chk("arst_valid", instr_valid, 0);
        @(negedge clk);
        rst_n = 1;
        mem_clr = 0;
        manual_rv = 1;
        fixed_en = 1;
        fixed_data = 16'h1234;
        @(negedge clk);
        manual_rv = 0;
        @(negedge clk);
        chk("late_rv_valid", instr_valid, 0);
        chk("late_rv_instr", instr, 0);
        chk("late_rv_pc", imem_addr, 8'h00);
        chk("late_rv_req", imem_req, 0);
        en = 1;
        @(negedge clk);
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_addr", imem_addr, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream neighbour of the instruction decoder/controller. Holds the program counter and issues single-outstanding reads to instruction memory. Latches the returned word into an instruction register and presents it, with a valid/ready handshake, as opcode/func fields to the controller. Consumes the controller's pc_flag together with a jump target to redirect the PC; otherwise the PC advances by one.

Parameters:
ADDR_W, 8, instruction memory word-address width; the PC wraps modulo 2^ADDR_W.
INSTR_W, 16, instruction width; must be at least 16.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  run enable; while low, no new fetch is started.
imem_req  out  1  one-cycle read strobe to instruction memory.
imem_addr  out  ADDR_W  read address; equals pc while imem_req is high.
imem_rvalid  in  1  read data valid; arrives at least 1 cycle after imem_req.
imem_rdata  in  INSTR_W  read data, qualified by imem_rvalid.
instr_valid  out  1  instruction register holds an unconsumed instruction.
instr_ready  in  1  controller accepts the presented instruction.
instr  out  INSTR_W  instruction register.
opcode  out  4  instr[15:12].
func  out  6  instr[5:0].
instr_pc  out  ADDR_W  address the presented instruction was fetched from.
pc_flag  in  1  jump request from the controller for the presented instruction.
jump_target  in  ADDR_W  jump destination, qualified by pc_flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. The active edge clears state immediately, independent of clk.
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, opcode=0, func=0, instr_pc=RESET_PC.
- All outputs are registered except opcode and func, which are wire slices of instr.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: when en=1, go to REQ next cycle; otherwise stay.
  - REQ: imem_req=1 for exactly this cycle with imem_addr=pc. Always go to WAIT. imem_rvalid is ignored in REQ (protocol violation, no effect).
  - WAIT: imem_req=0. On imem_rvalid=1: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to HOLD. Otherwise stay; there is no timeout.
  - HOLD: instr_valid=1 and instr stays stable until a handshake (instr_valid & instr_ready).
    - On handshake, pc <= pc_flag ? jump_target : pc+1 (mod 2^ADDR_W) and instr_valid<=0.
    - After the handshake, go to REQ if en=1, else IDLE.
- pc_flag and jump_target are sampled only in the handshake cycle and ignored at all other times.
- Latency: with 1-cycle memory, a handshake at cycle t gives imem_req at t+1, instr_valid at t+3. Maximum throughput is one instruction per 3 cycles at memory latency 1.
- Dropping en: a fetch already in REQ/WAIT completes and its instruction is presented; no further fetch starts. Re-asserting en in IDLE resumes from the current pc.
- Wrap-around: pc = 2^ADDR_W-1 followed by a non-jump handshake gives pc=0.
- A jump to the current pc is legal; that same address is re-fetched.
- A handshake with pc_flag=1 and en=0 updates pc to jump_target, then goes to IDLE.
- Reset mid-WAIT: state returns to IDLE. A late imem_rvalid after reset release is ignored, because rvalid only has effect in WAIT.
- At most one memory read is outstanding at any time.

Decomposition:
- Shared CPU package holds:
  - the opcode field positions (OPC_MSB=15, OPC_LSB=12, FUNC_MSB=5, FUNC_LSB=0), shared with the controller;
  - the FSM state encoding constants;
  - the default ADDR_W/INSTR_W.
- One natural sub-module: pc_reg (PC register with load, increment and reset value). The FSM and instruction register stay in the top.

Test Plan:
- Reset then en=1, memory latency 1, instr_ready=1, no jumps -> imem_addr sequence 0,1,2,3. instr_valid first high 3 cycles after reset release. instr_pc matches each address.
- Memory latency 4 with rdata=16'hF000 -> instr_valid rises 1 cycle after rvalid. opcode=4'hF, func=6'd0. Exactly one imem_req pulse per instruction.
- Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr stable, no imem_req. Raising instr_ready -> one handshake, pc+1, next req the following cycle.
- Jump: present 16'h9xxx, handshake with pc_flag=1 and jump_target=8'h40 -> next imem_addr=8'h40. pc_flag=1 without handshake -> no effect.
- Wrap: RESET_PC=8'hFF, one non-jump handshake -> next imem_addr=8'h00.
- Control interrupts:
  - en drops in WAIT -> instruction still presented; after handshake, state IDLE with no req.
  - rst_n asserted in WAIT, then rvalid after release -> instr_valid stays 0 and pc=RESET_PC.
